// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA) with valid/ready handshake, flush and tag passthrough.
// Define SHIFT_WORD_EN to add the in_word port for RV64 word ops (SLLW/SRLW/SRAW, DATA_W=64 only).
module shift_pipe #(
  parameter int  DATA_W     = 64,
  parameter int  NUM_STAGES = 2,
  parameter int  TAG_W      = 5,
  localparam int SHAMT_W    = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_a,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
`ifdef SHIFT_WORD_EN
  input  logic               in_word,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int LAST   = NUM_STAGES - 1;
  localparam int LEVELS = (SHAMT_W + NUM_STAGES - 1) / NUM_STAGES;

  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] move;
  logic [NUM_STAGES-1:0] load;
  logic                  chain;

  logic [DATA_W-1:0]  data_q  [NUM_STAGES];
  logic [SHAMT_W-1:0] shamt_q [NUM_STAGES];
  logic [1:0]         op_q    [NUM_STAGES];
  logic [TAG_W-1:0]   tag_q   [NUM_STAGES];

  logic [NUM_STAGES-1:0] src_valid;
  logic [DATA_W-1:0]     src_data  [NUM_STAGES];
  logic [SHAMT_W-1:0]    src_shamt [NUM_STAGES];
  logic [1:0]            src_op    [NUM_STAGES];
  logic [TAG_W-1:0]      src_tag   [NUM_STAGES];
  logic [DATA_W-1:0]     nxt_data  [NUM_STAGES];

  logic [DATA_W-1:0]  a_pre;
  logic [SHAMT_W-1:0] shamt_pre;

`ifdef SHIFT_WORD_EN
  logic word_q [NUM_STAGES];
  logic src_word [NUM_STAGES];

  // Word ops narrow the operand to 32 bits up front so the shared 64-bit datapath does the rest
  always_comb begin
    a_pre     = in_a;
    shamt_pre = in_shamt;
    if (in_word) begin
      shamt_pre = {{(SHAMT_W-5){1'b0}}, in_shamt[4:0]};
      if (in_op == 2'b11)
        a_pre = {{32{in_a[31]}}, in_a[31:0]};
      else if (in_op != 2'b00)
        a_pre = {32'b0, in_a[31:0]};
    end
  end
`else
  assign a_pre     = in_a;
  assign shamt_pre = in_shamt;
`endif

  // Stage k owns levels k*LEVELS up to (but excluding) (k+1)*LEVELS, capped at SHAMT_W
  function automatic logic [DATA_W-1:0] apply_levels(input logic [DATA_W-1:0] d,
                                                     input logic [SHAMT_W-1:0] sh,
                                                     input logic [1:0] op,
                                                     input int k);
    logic [DATA_W-1:0] r;
    r = d;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (i >= k * LEVELS && i < (k + 1) * LEVELS && sh[i]) begin
        case (op)
          2'b00:   r = r << (1 << i);
          2'b11:   r = $signed(r) >>> (1 << i);
          default: r = r >> (1 << i);
        endcase
      end
    end
    return r;
  endfunction

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = a_pre;
    src_shamt[0] = shamt_pre;
    src_op[0]    = in_op;
    src_tag[0]   = in_tag;
`ifdef SHIFT_WORD_EN
    src_word[0]  = in_word;
`endif
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_valid[k] = v_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_op[k]    = op_q[k-1];
      src_tag[k]   = tag_q[k-1];
`ifdef SHIFT_WORD_EN
      src_word[k]  = word_q[k-1];
`endif
    end
    for (int k = 0; k < NUM_STAGES; k++)
      nxt_data[k] = apply_levels(src_data[k], src_shamt[k], src_op[k], k);
  end

  // A stage can move on when out_ready holds or any later stage is empty
  always_comb begin
    chain = out_ready;
    move  = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      move[k] = chain;
      chain   = chain || !v_q[k];
    end
  end

  assign load     = ~v_q | move;
  assign in_ready = load[0] && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        tag_q[k]   <= '0;
`ifdef SHIFT_WORD_EN
        word_q[k]  <= 1'b0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (flush)
          v_q[k] <= 1'b0;
        else if (load[k])
          v_q[k] <= src_valid[k];
        if (!flush && load[k] && src_valid[k]) begin
          data_q[k]  <= nxt_data[k];
          shamt_q[k] <= src_shamt[k];
          op_q[k]    <= src_op[k];
          tag_q[k]   <= src_tag[k];
`ifdef SHIFT_WORD_EN
          word_q[k]  <= src_word[k];
`endif
        end
      end
    end
  end

  assign out_valid = v_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign busy      = |v_q;

`ifdef SHIFT_WORD_EN
  assign out_result = word_q[LAST] ? {{(DATA_W-32){data_q[LAST][31]}}, data_q[LAST][31:0]}
                                   : data_q[LAST];
`else
  assign out_result = data_q[LAST];
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed checks on a 2-stage shift_pipe, plus a shamt/op sweep across 1, 2 and 6 stage copies.
// Word-op vectors are included when SHIFT_WORD_EN is defined.
`timescale 1ns/1ps
module tb_shift_pipe;

  localparam int DW = 64;
  localparam int SW = 6;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] in_a = '0;
  logic [SW-1:0] in_shamt = '0;
  logic [1:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
`ifdef SHIFT_WORD_EN
  logic          in_word = 1'b0;
`endif

  logic          rdy1, val1, busy1, rdy2, val2, busy2, rdy6, val6, busy6;
  logic [DW-1:0] res1, res2, res6;
  logic [TW-1:0] tag1, tag2, tag6;

  int checks = 0;
  int passes = 0;

  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  logic [DW-1:0] q6[$];

  always #5 clk = ~clk;

  shift_pipe #(.DATA_W(DW), .NUM_STAGES(2), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
`ifdef SHIFT_WORD_EN
    .in_word(in_word),
`endif
    .out_valid(val2), .out_ready(out_ready), .out_result(res2), .out_tag(tag2), .busy(busy2)
  );

  shift_pipe #(.DATA_W(DW), .NUM_STAGES(1), .TAG_W(TW)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
`ifdef SHIFT_WORD_EN
    .in_word(in_word),
`endif
    .out_valid(val1), .out_ready(out_ready), .out_result(res1), .out_tag(tag1), .busy(busy1)
  );

  shift_pipe #(.DATA_W(DW), .NUM_STAGES(SW), .TAG_W(TW)) dut6 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy6),
    .in_a(in_a), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
`ifdef SHIFT_WORD_EN
    .in_word(in_word),
`endif
    .out_valid(val6), .out_ready(out_ready), .out_result(res6), .out_tag(tag6), .busy(busy6)
  );

  function automatic logic [DW-1:0] refShift(input logic [DW-1:0] a, input logic [SW-1:0] sh,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a << sh;
      2'b11:   return DW'($signed(a) >>> sh);
      default: return a >> sh;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checkOutput(name, DW'(got), DW'(exp));
  endtask

  task automatic applyStimulus(input logic [DW-1:0] a, input logic [SW-1:0] sh,
                               input logic [1:0] op, input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_a     = a;
    in_shamt = sh;
    in_op    = op;
    in_tag   = tag;
  endtask

  // One beat into an idle 2-stage pipe: invisible after the accepting edge, valid one edge later
  task automatic runOp(input string name, input logic [DW-1:0] a, input logic [SW-1:0] sh,
                       input logic [1:0] op, input logic [TW-1:0] tag, input logic [DW-1:0] exp);
    @(negedge clk);
    applyStimulus(a, sh, op, tag);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkBit({name, " early valid"}, val2, 1'b0);
    @(negedge clk);
    checkBit({name, " valid"}, val2, 1'b1);
    checkOutput({name, " result"}, res2, exp);
    checkOutput({name, " tag"}, DW'(tag2), DW'(tag));
  endtask

  task automatic sweepCycle(input logic v, input logic [DW-1:0] a, input logic [SW-1:0] sh,
                            input logic [1:0] op);
    @(negedge clk);
    if (val1) begin
      if (q1.size() == 0) checkBit("sweep ns1 unexpected valid", val1, 1'b0);
      else checkOutput("sweep ns1", res1, q1.pop_front());
    end
    if (val2) begin
      if (q2.size() == 0) checkBit("sweep ns2 unexpected valid", val2, 1'b0);
      else checkOutput("sweep ns2", res2, q2.pop_front());
    end
    if (val6) begin
      if (q6.size() == 0) checkBit("sweep ns6 unexpected valid", val6, 1'b0);
      else checkOutput("sweep ns6", res6, q6.pop_front());
    end
    in_valid = v;
    in_a     = a;
    in_shamt = sh;
    in_op    = op;
    in_tag   = TW'(sh);
    #1;
    if (v && rdy1) q1.push_back(refShift(a, sh, op));
    if (v && rdy2) q2.push_back(refShift(a, sh, op));
    if (v && rdy6) q6.push_back(refShift(a, sh, op));
  endtask

  initial begin
    int sent, got;
    logic prev_stall, saw_full;
    logic [DW-1:0] held_res;
    logic [TW-1:0] held_tag;

    // Reset held with a live request on the input
    rst_n = 1'b0;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 2'b00, 5'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("reset out_valid", val2, 1'b0);
    checkBit("reset busy", busy2, 1'b0);
    checkOutput("reset out_result", res2, '0);
    checkOutput("reset out_tag", DW'(tag2), '0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    checkBit("reset in_ready", rdy2, 1'b1);

    runOp("sll 4",  64'h8000_0000_0000_00F0, 6'd4,  2'b00, 5'd1, 64'h0000_0000_0000_0F00);
    runOp("srl 4",  64'h8000_0000_0000_00F0, 6'd4,  2'b01, 5'd2, 64'h0800_0000_0000_000F);
    runOp("srl10 4",64'h8000_0000_0000_00F0, 6'd4,  2'b10, 5'd3, 64'h0800_0000_0000_000F);
    runOp("sra 4",  64'h8000_0000_0000_00F0, 6'd4,  2'b11, 5'd4, 64'hF800_0000_0000_000F);
    runOp("sll 63", 64'h1,                   6'd63, 2'b00, 5'd5, 64'h8000_0000_0000_0000);
    runOp("sra 0",  64'h8123_4567_89AB_CDEF, 6'd0,  2'b11, 5'd6, 64'h8123_4567_89AB_CDEF);
    runOp("sra 63", 64'h8000_0000_0000_0000, 6'd63, 2'b11, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF);

    // Six beats with out_ready low for three cycles mid-stream
    sent = 0; got = 0; prev_stall = 1'b0; saw_full = 1'b0;
    held_res = '0; held_tag = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c < 6);
      if (sent < 6) applyStimulus(DW'(64'hF0 + sent), SW'(sent), 2'b00, TW'(sent));
      else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        checkOutput("bp hold result", res2, held_res);
        checkOutput("bp hold tag", DW'(tag2), DW'(held_tag));
      end
      if (!rdy2 && sent < 6) saw_full = 1'b1;
      prev_stall = val2 && !out_ready;
      held_res   = res2;
      held_tag   = tag2;
      if (val2 && out_ready) begin
        checkOutput("bp tag order", DW'(tag2), DW'(got));
        checkOutput("bp result", res2, refShift(DW'(64'hF0 + got), SW'(got), 2'b00));
        got++;
      end
      if (in_valid && rdy2) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp beats delivered", DW'(got), DW'(6));
    checkBit("bp in_ready dropped", saw_full, 1'b1);

    // Fill both stages, then flush with a request pending and the consumer ready
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(64'h1, 6'd1, 2'b00, 5'd10);
    @(negedge clk);
    applyStimulus(64'h2, 6'd1, 2'b00, 5'd11);
    @(negedge clk);
    checkBit("fill busy", busy2, 1'b1);
    checkBit("fill out_valid", val2, 1'b1);
    checkOutput("fill out_tag", DW'(tag2), DW'(10));
    applyStimulus(64'h3, 6'd1, 2'b00, 5'd12);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checkBit("flush in_ready", rdy2, 1'b0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkBit("flush out_valid", val2, 1'b0);
    checkBit("flush busy", busy2, 1'b0);
    runOp("post flush", 64'h3, 6'd1, 2'b00, 5'd13, 64'h6);

`ifdef SHIFT_WORD_EN
    in_word = 1'b1;
    runOp("srlw 1",  64'hFFFF_FFFF_8000_0000, 6'd1,  2'b01, 5'd14, 64'h0000_0000_4000_0000);
    runOp("sraw 1",  64'hFFFF_FFFF_8000_0000, 6'd1,  2'b11, 5'd15, 64'hFFFF_FFFF_C000_0000);
    runOp("sllw 33", 64'h0000_0000_4000_0000, 6'd33, 2'b00, 5'd16, 64'hFFFF_FFFF_8000_0000);
    in_word = 1'b0;
`endif

    // Sweep every shamt and op back-to-back on the 1-, 2- and 6-stage copies
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int op = 0; op < 4; op++)
      for (int sh = 0; sh < 64; sh++)
        sweepCycle(1'b1, {$urandom(), $urandom()}, SW'(sh), op[1:0]);
    for (int c = 0; c < 10; c++)
      sweepCycle(1'b0, '0, '0, 2'b00);
    checkOutput("sweep ns1 drained", DW'(q1.size()), '0);
    checkOutput("sweep ns2 drained", DW'(q2.size()), '0);
    checkOutput("sweep ns6 drained", DW'(q6.size()), '0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
